// File: rtl/sram_responder_pkg.sv
// Shared types, defaults and helpers for the sram_responder slice.
// The `SRAM_* defines below are the build-wide parameter defaults.
`ifndef SRAM_RESPONDER_DEFINES
`define SRAM_RESPONDER_DEFINES
`define SRAM_ADDR_BASE  32'hBFC0_0000
`define SRAM_DEPTH_LOG2 14
`define SRAM_WORD_WD    32
`endif

package sram_responder_pkg;

  localparam int WORD_WD = `SRAM_WORD_WD;
  localparam int BYTES   = WORD_WD / 8;

  typedef logic [WORD_WD-1:0] word_t;
  typedef logic [BYTES-1:0]   wen_t;

  // Saturating add used by the error counter; a cycle can add at most 2.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Core-side SRAM bus: one read-only instruction port and one byte-enabled data port.
// The core drives through 'master'; the responder sits on 'slave'.
interface sram_responder_if;
  import sram_responder_pkg::*;

  logic        inst_sram_en;
  wen_t        inst_sram_wen;
  logic [31:0] inst_sram_addr;
  word_t       inst_sram_wdata;
  word_t       inst_sram_rdata;

  logic        data_sram_en;
  wen_t        data_sram_wen;
  logic [31:0] data_sram_addr;
  word_t       data_sram_wdata;
  word_t       data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );

endinterface

// File: rtl/sram_byte_merge.sv
// Combinational byte-lane merge: lanes with wen set take wdata, the rest keep old_word.
// With wen == 0 the output is simply old_word, so the same result also serves plain reads.
module sram_byte_merge
  import sram_responder_pkg::*;
(
  input  word_t old_word,
  input  word_t wdata,
  input  wen_t  wen,
  output word_t new_word
);

  // Replace each enabled byte lane of the stored word.
  always_comb begin
    new_word = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (wen[i]) new_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the core's inst/data SRAM ports, one shared word array.
// Read data is registered: valid the cycle after en, held while en is low.
// Optional build macro SRAM_RESPONDER_ERRCNT_EN adds a saturating 16-bit error counter;
// without it err_cnt is tied to zero.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = `SRAM_ADDR_BASE,
  parameter int          DEPTH_LOG2 = `SRAM_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   bus,
  output logic              err_oor,
  output logic [15:0]       err_cnt
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN  = 32'd4 << DEPTH_LOG2;

  word_t mem [0:DEPTH-1];

  logic [31:0]           inst_off, data_off;
  logic                  inst_in_range, data_in_range;
  logic [DEPTH_LOG2-1:0] inst_idx, data_idx;
  logic                  inst_rd, data_wr, collision;
  logic                  inst_err, data_err;
  word_t                 merged;
  word_t                 inst_rdata_q, data_rdata_q;

  // The instruction port never writes, so its store data is deliberately ignored.
  logic unused_inst_wdata;
  assign unused_inst_wdata = ^bus.inst_sram_wdata;

  // Offsets wrap mod 2^32, so addresses below the base land far out of range.
  assign inst_off      = bus.inst_sram_addr - ADDR_BASE;
  assign data_off      = bus.data_sram_addr - ADDR_BASE;
  assign inst_in_range = inst_off < SPAN;
  assign data_in_range = data_off < SPAN;
  assign inst_idx      = inst_off[DEPTH_LOG2+1:2];
  assign data_idx      = data_off[DEPTH_LOG2+1:2];

  assign inst_rd   = bus.inst_sram_en && inst_in_range;
  assign data_wr   = bus.data_sram_en && (bus.data_sram_wen != '0) && data_in_range;
  assign collision = inst_rd && data_wr && (inst_idx == data_idx);

  // Each port contributes at most one error event per cycle.
  assign inst_err = bus.inst_sram_en && (!inst_in_range || (bus.inst_sram_wen != '0));
  assign data_err = bus.data_sram_en && !data_in_range;

  // One merge feeds the array write, data write-first and inst forwarding.
  sram_byte_merge u_merge (
    .old_word (mem[data_idx]),
    .wdata    (bus.data_sram_wdata),
    .wen      (bus.data_sram_wen),
    .new_word (merged)
  );

  // Array write; a clock edge seen while reset is high performs no write.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (data_wr) mem[data_idx] <= merged;
    end
  end

  // Read-data registers: load on en, hold otherwise, zero for out-of-range accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (bus.inst_sram_en) begin
        if (!inst_in_range) inst_rdata_q <= '0;
        else if (collision) inst_rdata_q <= merged;
        else                inst_rdata_q <= mem[inst_idx];
      end
      if (bus.data_sram_en) begin
        data_rdata_q <= data_in_range ? merged : '0;
      end
    end
  end

  assign bus.inst_sram_rdata = inst_rdata_q;
  assign bus.data_sram_rdata = data_rdata_q;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_oor <= 1'b0;
    else if (inst_err || data_err) err_oor <= 1'b1;
  end

`ifdef SRAM_RESPONDER_ERRCNT_EN
  logic [1:0]  err_inc;
  logic [15:0] err_cnt_q;
  assign err_inc = {1'b0, inst_err} + {1'b0, data_err};

  // Saturating count of error events, two per cycle when both ports fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 16'h0;
    else     err_cnt_q <= sat_add16(err_cnt_q, err_inc);
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them on the cycle they are due.
module tb_sram_responder;
  import sram_responder_pkg::*;

  localparam logic [31:0] B = 32'hBFC0_0000;
`ifdef SRAM_RESPONDER_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  localparam int K_INST = 0;
  localparam int K_DATA = 1;
  localparam int K_OOR  = 2;
  localparam int K_CNT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err_oor;
  logic [15:0] err_cnt;

  sram_responder_if bus();

  sram_responder dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_oor (err_oor),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   passed  = 0;
  int   total   = 0;
  int   exp_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_INST:  return bus.inst_sram_rdata;
      K_DATA:  return bus.data_sram_rdata;
      K_OOR:   return {31'b0, err_oor};
      default: return {16'b0, err_cnt};
    endcase
  endfunction

  // Expectation for the response to the stimulus just driven.
  task automatic expectNext(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expectCnt(input string name);
    expectNext(K_CNT, ERRCNT ? 32'(exp_cnt) : 32'h0, name);
  endtask

  // Drive one cycle of requests just after a rising edge.
  task automatic applyStimulus(input logic ie, input logic [3:0] iw, input logic [31:0] ia,
                               input logic de, input logic [3:0] dw, input logic [31:0] da,
                               input logic [31:0] dd);
    @(posedge clk);
    #1;
    bus.inst_sram_en    = ie;
    bus.inst_sram_wen   = iw;
    bus.inst_sram_addr  = ia;
    bus.inst_sram_wdata = (iw != 4'h0) ? 32'hFFFF_FFFF : 32'h0;
    bus.data_sram_en    = de;
    bus.data_sram_wen   = dw;
    bus.data_sram_addr  = da;
    bus.data_sram_wdata = dd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Monitor: compare every expectation that has come due.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput(e.name, actual(e.kind), e.val);
    end
  end

  initial begin
    int guard;
    exp_t e;
    bus.inst_sram_en = 0; bus.inst_sram_wen = 0; bus.inst_sram_addr = 0; bus.inst_sram_wdata = 0;
    bus.data_sram_en = 0; bus.data_sram_wen = 0; bus.data_sram_addr = 0; bus.data_sram_wdata = 0;

    #1 rst = 1'b1;
    #11;
    checkOutput("reset_inst_rdata", bus.inst_sram_rdata, 32'h0);
    checkOutput("reset_data_rdata", bus.data_sram_rdata, 32'h0);
    checkOutput("reset_err_oor", {31'b0, err_oor}, 32'h0);
    checkOutput("reset_err_cnt", {16'b0, err_cnt}, 32'h0);
    rst = 1'b0;

    // Preload word 0, fetch it, then let it hold.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, B, 32'h3C08_BFAF);
    expectNext(K_DATA, 32'h3C08_BFAF, "t1_preload_wf");
    applyStimulus(1, 4'h0, B, 0, 4'h0, 32'h0, 32'h0);
    expectNext(K_INST, 32'h3C08_BFAF, "t1_inst_read");
    idle();
    expectNext(K_INST, 32'h3C08_BFAF, "t1_inst_hold");
    expectNext(K_DATA, 32'h3C08_BFAF, "t1_data_hold");

    // Partial store over an existing word.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, B + 32'h10, 32'h1122_3344);
    expectNext(K_DATA, 32'h1122_3344, "t2_preload");
    applyStimulus(0, 4'h0, 32'h0, 1, 4'b0011, B + 32'h10, 32'hAABB_CCDD);
    expectNext(K_DATA, 32'h1122_CCDD, "t2_partial_wf");
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, B + 32'h10, 32'h0);
    expectNext(K_DATA, 32'h1122_CCDD, "t2_reread");

    // Same-cycle write and fetch of one word, then a shared read.
    applyStimulus(1, 4'h0, B + 32'h10, 1, 4'hF, B + 32'h10, 32'hDEAD_BEEF);
    expectNext(K_INST, 32'hDEAD_BEEF, "t3_inst_fwd");
    expectNext(K_DATA, 32'hDEAD_BEEF, "t3_data_wf");
    applyStimulus(1, 4'h0, B + 32'h10, 1, 4'h0, B + 32'h10, 32'h0);
    expectNext(K_INST, 32'hDEAD_BEEF, "dual_read_inst");
    expectNext(K_DATA, 32'hDEAD_BEEF, "dual_read_data");
    expectNext(K_OOR, 32'h0, "no_err_yet");

    // Errors: out-of-range read, then a nonzero inst wen.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
    exp_cnt = 1;
    expectNext(K_DATA, 32'h0, "t4_oor_rdata");
    expectNext(K_OOR, 32'h1, "t4_err_oor");
    expectCnt("t4_err_cnt1");
    applyStimulus(1, 4'h1, B, 0, 4'h0, 32'h0, 32'h0);
    exp_cnt = 2;
    expectNext(K_INST, 32'h3C08_BFAF, "t4_inst_wen_read");
    expectCnt("t4_err_cnt2");
    applyStimulus(1, 4'h0, B, 0, 4'h0, 32'h0, 32'h0);
    expectNext(K_INST, 32'h3C08_BFAF, "t4_no_array_change");

    // Range boundaries: last word, one past the end, below the base.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, B + 32'hFFFC, 32'h1234_5678);
    expectNext(K_DATA, 32'h1234_5678, "last_word_wf");
    expectCnt("last_word_no_err");
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, B + 32'h1_0000, 32'h0);
    exp_cnt = 3;
    expectNext(K_DATA, 32'h0, "past_end_rdata");
    expectCnt("past_end_cnt");
    applyStimulus(1, 4'h0, B - 32'h4, 1, 4'h0, B + 32'h1_0000, 32'h0);
    exp_cnt = 5;
    expectNext(K_INST, 32'h0, "below_base_inst");
    expectCnt("two_err_cnt");
    applyStimulus(1, 4'h0, B + 32'h10, 1, 4'h0, B + 32'hFFFC, 32'h0);
    expectNext(K_INST, 32'hDEAD_BEEF, "pre_rst_inst");
    expectNext(K_DATA, 32'h1234_5678, "pre_rst_data");
    expectCnt("pre_rst_cnt");
    idle();
    idle();

    // Reset mid-stream with a write pending on the edge it covers.
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = 4'hF;
    bus.data_sram_addr  = B + 32'h10;
    bus.data_sram_wdata = 32'h0BAD_F00D;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_inst_rdata", bus.inst_sram_rdata, 32'h0);
    checkOutput("rst_data_rdata", bus.data_sram_rdata, 32'h0);
    checkOutput("rst_err_oor", {31'b0, err_oor}, 32'h0);
    checkOutput("rst_err_cnt", {16'b0, err_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.data_sram_en  = 1'b0;
    bus.data_sram_wen = 4'h0;
    exp_cnt = 0;
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, B + 32'h10, 32'h0);
    expectNext(K_DATA, 32'hDEAD_BEEF, "post_rst_read");
    expectNext(K_INST, 32'h0, "post_rst_inst_hold");
    expectNext(K_OOR, 32'h0, "post_rst_oor");

    // Back-to-back reads with no bubbles.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, B + 32'h4, 32'hCAFE_0004);
    expectNext(K_DATA, 32'hCAFE_0004, "b2b_fill4");
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, B + 32'h8, 32'hCAFE_0008);
    expectNext(K_DATA, 32'hCAFE_0008, "b2b_fill8");
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, B, 32'h0);
    expectNext(K_DATA, 32'h3C08_BFAF, "b2b_read0");
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, B + 32'h4, 32'h0);
    expectNext(K_DATA, 32'hCAFE_0004, "b2b_read4");
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, B + 32'h8, 32'h0);
    expectNext(K_DATA, 32'hCAFE_0008, "b2b_read8");
    expectCnt("final_cnt");
    idle();

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      $display("[TB] FAIL %s: never compared, required %h", e.name, e.val);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
